// File: rtl/seg7_pkg.sv
// Shared constants, types and helpers for the seven-segment scan display.
package seg7_pkg;

  localparam int unsigned SEG_W = 8;
  localparam int unsigned SEG_H = 0;

  typedef logic [SEG_W-1:0] seg_t;

  localparam seg_t SEG_DOT_MASK = seg_t'(1) << SEG_H;

  // Active-high pattern, bit7=a .. bit1=g, bit0=h (dot, always clear here).
  function automatic seg_t hex_to_seg(input logic [3:0] nib);
    seg_t s;
    case (nib)
      4'h0: s = 8'hFC;
      4'h1: s = 8'h60;
      4'h2: s = 8'hDA;
      4'h3: s = 8'hF2;
      4'h4: s = 8'h66;
      4'h5: s = 8'hB6;
      4'h6: s = 8'hBE;
      4'h7: s = 8'hE0;
      4'h8: s = 8'hFE;
      4'h9: s = 8'hF6;
      4'hA: s = 8'hEE;
      4'hB: s = 8'h3E;
      4'hC: s = 8'h9C;
      4'hD: s = 8'h7A;
      4'hE: s = 8'h9E;
      default: s = 8'h8E;
    endcase
    return s;
  endfunction

  function automatic int unsigned calc_div(input int unsigned clk_hz,
                                           input int unsigned scan_hz,
                                           input int unsigned n_digits);
    return clk_hz / (scan_hz * n_digits);
  endfunction

endpackage

// File: rtl/seg7_scan_display_if.sv
// Host-side load/config and pin-side outputs of the scan display.
interface seg7_scan_display_if #(
  parameter int unsigned N_DIGITS = 8,
  parameter int unsigned BRIGHT_W = 4
);
  logic                    load;
  logic [4*N_DIGITS-1:0]   value;
  logic [N_DIGITS-1:0]     dots;
  logic                    blank_lz;
  logic [BRIGHT_W-1:0]     bright;
  logic [7:0]              abcdefgh;
  logic [N_DIGITS-1:0]     digit;
  logic                    frame_done;

  modport master (output load, value, dots, blank_lz, bright,
                  input  abcdefgh, digit, frame_done);
  modport slave  (input  load, value, dots, blank_lz, bright,
                  output abcdefgh, digit, frame_done);
endinterface

// File: rtl/seg7_hex_decoder.sv
// Nibble plus dot to active-high segment pattern; polarity is handled by the caller.
module seg7_hex_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  input  logic       dot,
  output seg_t       seg_c
);

  always_comb begin
    seg_c        = hex_to_seg(nib);
    seg_c[SEG_H] = dot;
  end

endmodule

// File: rtl/seg7_scan_display.sv
// Time-multiplexed hex display: frame-synchronous double buffer, leading-zero
// blanking and PWM brightness, with segment and digit pins registered together.
module seg7_scan_display
  import seg7_pkg::*;
#(
  parameter int unsigned CLK_HZ           = 50_000_000,
  parameter int unsigned SCAN_HZ          = 1000,
  parameter int unsigned N_DIGITS         = 8,
  parameter int unsigned SEG_ACTIVE_LOW   = 1,
  parameter int unsigned DIGIT_ACTIVE_LOW = 1,
  parameter int unsigned BRIGHT_W         = 4
) (
  input logic               clk,
  input logic               rst_n,
  seg7_scan_display_if.slave bus
);

  localparam int unsigned DIV   = calc_div(CLK_HZ, SCAN_HZ, N_DIGITS);
  localparam int unsigned DIV_W = (DIV < 2) ? 1 : $clog2(DIV);
  localparam int unsigned IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int unsigned VAL_W = 4 * N_DIGITS;

  localparam seg_t                SEG_OFF = {SEG_W{SEG_ACTIVE_LOW != 0}};
  localparam logic [N_DIGITS-1:0] DIG_OFF = {N_DIGITS{DIGIT_ACTIVE_LOW != 0}};

  if (DIV < 2) begin : g_bad_div
    $error("seg7_scan_display: DIV=%0d must be at least 2", DIV);
  end
  if (N_DIGITS < 1 || N_DIGITS > 8) begin : g_bad_n
    $error("seg7_scan_display: N_DIGITS=%0d out of range 1..8", N_DIGITS);
  end

  logic [DIV_W-1:0]    div_q;
  logic [IDX_W-1:0]    idx_q;
  logic [BRIGHT_W-1:0] pwm_q;
  logic [VAL_W-1:0]    shadow_val_q, disp_val_q;
  logic [N_DIGITS-1:0] shadow_dots_q, disp_dots_q;
  logic                pending_q;
  seg_t                seg_q;
  logic [N_DIGITS-1:0] dig_q;
  logic                fd_q;

  logic                tick_c, commit_c, en_c, blank_c, dot_c, zero_run_c;
  logic [3:0]          nib_c;
  logic [N_DIGITS-1:0] onehot_c;
  seg_t                pat_c, seg_hi_c;

  assign tick_c   = (div_q == DIV_W'(DIV - 1));
  assign commit_c = tick_c && (idx_q == IDX_W'(N_DIGITS - 1));
  assign en_c     = (pwm_q < bus.bright) || (&bus.bright);

  // Scan timebase and free-running PWM counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
      idx_q <= '0;
      pwm_q <= '0;
    end else begin
      div_q <= tick_c ? '0 : div_q + DIV_W'(1);
      pwm_q <= pwm_q + BRIGHT_W'(1);
      if (tick_c) idx_q <= commit_c ? '0 : idx_q + IDX_W'(1);
    end
  end

  // Load wins over commit for pending, so a load on the commit edge waits a frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_val_q  <= '0;
      shadow_dots_q <= '0;
      disp_val_q    <= '0;
      disp_dots_q   <= '0;
      pending_q     <= 1'b0;
    end else begin
      if (commit_c) begin
        if (pending_q) begin
          disp_val_q  <= shadow_val_q;
          disp_dots_q <= shadow_dots_q;
        end
        pending_q <= 1'b0;
      end
      if (bus.load) begin
        shadow_val_q  <= bus.value;
        shadow_dots_q <= bus.dots;
        pending_q     <= 1'b1;
      end
    end
  end

  // Select current digit; zero_run tracks "all nibbles from the top down to i are zero".
  always_comb begin
    nib_c      = 4'h0;
    dot_c      = 1'b0;
    blank_c    = 1'b0;
    onehot_c   = '0;
    zero_run_c = 1'b1;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      zero_run_c = zero_run_c && (disp_val_q[4*i +: 4] == 4'h0);
      if (idx_q == IDX_W'(i)) begin
        nib_c       = disp_val_q[4*i +: 4];
        dot_c       = disp_dots_q[i];
        blank_c     = bus.blank_lz && zero_run_c && (i != 0);
        onehot_c[i] = 1'b1;
      end
    end
  end

  seg7_hex_decoder u_dec (
    .nib   (nib_c),
    .dot   (dot_c),
    .seg_c (pat_c)
  );

  assign seg_hi_c = blank_c ? (pat_c & SEG_DOT_MASK) : pat_c;

  // Pin stage: segments and digit enable update on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q <= SEG_OFF;
      dig_q <= DIG_OFF;
      fd_q  <= 1'b0;
    end else begin
      seg_q <= seg_hi_c ^ SEG_OFF;
      dig_q <= (en_c ? onehot_c : '0) ^ DIG_OFF;
      fd_q  <= commit_c;
    end
  end

  assign bus.abcdefgh   = seg_q;
  assign bus.digit      = dig_q;
  assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Directed scoreboard bench for seg7_scan_display (4 digits, DIV=10, active-low pins).
module tb_seg7_scan_display;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  seg7_scan_display_if #(.N_DIGITS(4), .BRIGHT_W(4)) bus ();

  seg7_scan_display #(
    .CLK_HZ(1000), .SCAN_HZ(25), .N_DIGITS(4),
    .SEG_ACTIVE_LOW(1), .DIGIT_ACTIVE_LOW(1), .BRIGHT_W(4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  localparam logic [7:0] HEX_TAB [16] = '{
    8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
    8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E};

  typedef struct {
    string       tag;
    logic [12:0] v;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  function automatic logic [12:0] pins();
    return {bus.frame_done, bus.digit, bus.abcdefgh};
  endfunction

  // Expected {frame_done, digit, abcdefgh} for sample k (0..39) of a frame.
  function automatic logic [12:0] exp_vec(input logic [15:0] val, input logic [3:0] dts,
                                          input logic blank, input int k);
    int         d;
    logic [3:0] nib;
    logic [7:0] hi;
    logic [3:0] dig;
    d   = k / 10;
    nib = 4'(val >> (4 * d));
    dig = ~(4'b0001 << d);
    hi  = HEX_TAB[nib] | {7'b0, dts[d]};
    if (blank && d != 0 && (val >> (4 * d)) == 16'h0) hi = {7'b0, dts[d]};
    return {k == 39, dig, ~hi};
  endfunction

  task automatic push(input string tag, input logic [12:0] v);
    exp_t e;
    e.tag = tag;
    e.v   = v;
    sb.push_back(e);
  endtask

  task automatic check(input logic [12:0] obs);
    exp_t e;
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $error("FAIL sb_empty observed=%h", obs);
      return;
    end
    e = sb.pop_front();
    assert (obs === e.v) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.v);
    end
  endtask

  // Entered at the negedge where frame_done was seen; checks one full frame and
  // optionally pulses load after sample ld1_at / ld2_at.
  task automatic frame_check(input string tag, input logic [15:0] val, input logic [3:0] dts,
                             input logic blank,
                             input int ld1_at, input logic [15:0] ld1_val, input logic [3:0] ld1_dots,
                             input int ld2_at, input logic [15:0] ld2_val);
    for (int k = 0; k < 40; k++) push($sformatf("%s_k%0d", tag, k), exp_vec(val, dts, blank, k));
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      @(negedge clk);
      check(pins());
      bus.load = 1'b0;
      if (k == ld1_at) begin
        bus.load = 1'b1; bus.value = ld1_val; bus.dots = ld1_dots;
      end
      if (k == ld2_at) begin
        bus.load = 1'b1; bus.value = ld2_val; bus.dots = ld1_dots;
      end
    end
  endtask

  task automatic pwm_window(input string tag, input logic [3:0] br, input int n, input int exp_on);
    int on_cnt;
    int multi;
    on_cnt = 0;
    multi  = 0;
    bus.bright = br;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.digit != 4'hF) on_cnt++;
      if ($countones(~bus.digit) > 1) multi++;
    end
    push(tag, 13'(exp_on));
    check(13'(on_cnt));
    push({tag, "_onehot"}, 13'd0);
    check(13'(multi));
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.load     = 1'b0;
    bus.value    = '0;
    bus.dots     = '0;
    bus.blank_lz = 1'b0;
    bus.bright   = 4'hF;
    repeat (3) @(negedge clk);
    push("reset", {1'b0, 4'hF, 8'hFF});
    check(pins());
    rst_n = 1'b1;

    // First frame after reset shows 0000; load 12AF early so it commits at edge 40.
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      @(negedge clk);
      push($sformatf("post_reset_n%0d", n), exp_vec(16'h0, 4'h0, 1'b0, n - 1));
      check(pins());
      bus.load = 1'b0;
      if (n == 2) begin
        bus.load = 1'b1; bus.value = 16'h12AF; bus.dots = 4'h0;
      end
    end

    frame_check("scan",     16'h12AF, 4'h0, 1'b0, -1, 16'h0, 4'h0, -1, 16'h0);
    frame_check("tear_old", 16'h12AF, 4'h0, 1'b0,  5, 16'h1111, 4'h0, 20, 16'h2222);
    frame_check("tear_new", 16'h2222, 4'h0, 1'b0, 38, 16'h0008, 4'h0, -1, 16'h0);
    frame_check("cmt_old",  16'h2222, 4'h0, 1'b0, -1, 16'h0, 4'h0, -1, 16'h0);
    frame_check("cmt_new",  16'h0008, 4'h0, 1'b0, 10, 16'h0008, 4'b0100, -1, 16'h0);
    frame_check("dots_on",  16'h0008, 4'b0100, 1'b0, -1, 16'h0, 4'h0, -1, 16'h0);
    bus.blank_lz = 1'b1;
    frame_check("blank",    16'h0008, 4'b0100, 1'b1, -1, 16'h0, 4'h0, -1, 16'h0);

    pwm_window("bright4",   4'h4, 16, 4);
    pwm_window("bright4x2", 4'h4, 32, 8);
    pwm_window("bright0",   4'h0, 40, 0);
    pwm_window("bright15",  4'hF, 16, 16);

    // Asynchronous reset mid-frame must blank the pins without waiting for an edge.
    repeat (13) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    push("async_reset", {1'b0, 4'hF, 8'hFF});
    check(pins());
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
